// File: rtl/unibus_intr_arb.sv
// unibus_intr_arb: shares one Unibus BR level among NDEV level-style interrupt
// requesters. It picks a winner round-robin and runs the BR/BG/SACK/BBSY/INTR
// vector transaction for that winner. It passes BG downstream when nobody here
// wants it, and pulses intgnt with the delivered vector. All bus outputs are
// registered.
module unibus_intr_arb #(
    parameter int unsigned NDEV = 4,
    parameter int unsigned TMO  = 1023
) (
    input  logic              CLOCK,
    input  logic              RESET,
    input  logic              init_in_h,
    input  logic [NDEV-1:0]   dev_intreq,
    input  logic [8*NDEV-1:0] dev_irvec,
    output logic              intgnt,
    output logic [7:0]        igvec,
    input  logic              bg_in_h,
    output logic              bg_out_h,
    output logic              br_out_h,
    output logic              sack_out_h,
    input  logic              bbsy_in_h,
    output logic              bbsy_out_h,
    output logic              intr_out_h,
    input  logic              ssyn_in_h,
    output logic [15:0]       d_out_h,
    output logic              tmo_err
);

    localparam int unsigned IW = (NDEV > 1) ? $clog2(NDEV) : 1;
    localparam int unsigned CW = $clog2(TMO + 1);

    typedef enum logic [2:0] {IDLE, REQ, ACK, WAITBUS, XFER, DONE, RELEASE} state_t;

    state_t         state_q, state_d;
    logic [IW-1:0]  rr_q, rr_d;
    logic [IW-1:0]  win_q, win_d;
    logic [7:0]     vec_q, vec_d;
    logic [CW-1:0]  cnt_q, cnt_d;
    logic           tmo_err_q, tmo_err_d;
    logic           intgnt_q, intgnt_d;
    logic [7:0]     igvec_q, igvec_d;
    logic           bg_out_q, bg_out_d;
    logic           br_q, br_d;
    logic           sack_q, sack_d;
    logic           bbsy_q, bbsy_d;
    logic           intr_q, intr_d;
    logic [15:0]    d_out_q, d_out_d;

    logic           sel_found;
    logic [IW-1:0]  sel_idx;
    logic [7:0]     sel_vec;
    int unsigned    cand;

    // Round-robin pick: first requesting device at or above rr, wrapping.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        cand      = 0;
        for (int unsigned i = 0; i < NDEV; i++) begin
            cand = (32'(rr_q) + i) % NDEV;
            if (!sel_found && dev_intreq[cand[IW-1:0]]) begin
                sel_found = 1'b1;
                sel_idx   = cand[IW-1:0];
            end
        end
        sel_vec = dev_irvec[{sel_idx, 3'b000} +: 8];
    end

    // Next-state logic. The bus outputs are decoded from the next state so
    // that each registered output lines up with the state it belongs to.
    always_comb begin
        state_d   = state_q;
        rr_d      = rr_q;
        win_d     = win_q;
        vec_d     = vec_q;
        cnt_d     = cnt_q;
        tmo_err_d = tmo_err_q;
        unique case (state_q)
            IDLE: begin
                if (sel_found) begin
                    win_d   = sel_idx;
                    vec_d   = sel_vec;
                    state_d = REQ;
                end
            end
            REQ: begin
                if (bg_in_h)
                    state_d = ACK;
                else if (!dev_intreq[win_q])
                    state_d = IDLE;
            end
            ACK: begin
                if (!bg_in_h)
                    state_d = WAITBUS;
            end
            WAITBUS: begin
                if (!bbsy_in_h && !ssyn_in_h) begin
                    state_d = XFER;
                    cnt_d   = '0;
                end
            end
            XFER: begin
                if (ssyn_in_h) begin
                    state_d = DONE;
                end else if (cnt_q == CW'(TMO - 1)) begin
                    tmo_err_d = 1'b1;
                    state_d   = RELEASE;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            DONE: begin
                rr_d    = (win_q == IW'(NDEV - 1)) ? '0 : win_q + 1'b1;
                state_d = RELEASE;
            end
            RELEASE: begin
                if (!ssyn_in_h)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        br_d     = (state_d == REQ);
        sack_d   = (state_d == ACK) || (state_d == WAITBUS);
        bbsy_d   = (state_d == XFER);
        intr_d   = (state_q == XFER) && (state_d == XFER);
        d_out_d  = bbsy_d ? {8'b0, vec_q} : '0;
        intgnt_d = (state_d == DONE);
        igvec_d  = (state_d == DONE) ? vec_q : igvec_q;
        // BG is withheld in IDLE whenever a local request is pending: that
        // grant will be captured in REQ, so it must never be forwarded as well.
        bg_out_d = bg_in_h && (state_q == IDLE) && !(|dev_intreq);
    end

    // State and output registers; RESET and bus INIT abort everything.
    always_ff @(posedge CLOCK) begin
        if (RESET || init_in_h) begin
            state_q   <= IDLE;
            rr_q      <= '0;
            win_q     <= '0;
            vec_q     <= '0;
            cnt_q     <= '0;
            tmo_err_q <= 1'b0;
            intgnt_q  <= 1'b0;
            igvec_q   <= '0;
            bg_out_q  <= 1'b0;
            br_q      <= 1'b0;
            sack_q    <= 1'b0;
            bbsy_q    <= 1'b0;
            intr_q    <= 1'b0;
            d_out_q   <= '0;
        end else begin
            state_q   <= state_d;
            rr_q      <= rr_d;
            win_q     <= win_d;
            vec_q     <= vec_d;
            cnt_q     <= cnt_d;
            tmo_err_q <= tmo_err_d;
            intgnt_q  <= intgnt_d;
            igvec_q   <= igvec_d;
            bg_out_q  <= bg_out_d;
            br_q      <= br_d;
            sack_q    <= sack_d;
            bbsy_q    <= bbsy_d;
            intr_q    <= intr_d;
            d_out_q   <= d_out_d;
        end
    end

    assign intgnt     = intgnt_q;
    assign igvec      = igvec_q;
    assign bg_out_h   = bg_out_q;
    assign br_out_h   = br_q;
    assign sack_out_h = sack_q;
    assign bbsy_out_h = bbsy_q;
    assign intr_out_h = intr_q;
    assign d_out_h    = d_out_q;
    assign tmo_err    = tmo_err_q;

endmodule

// File: tb/tb_unibus_intr_arb.sv
// Self-checking bench for unibus_intr_arb. Expected vectors are queued when a
// request is raised and popped when the DUT pulses intgnt.
module tb_unibus_intr_arb;

    localparam int unsigned NDEV = 4;
    localparam int unsigned TMO  = 40;

    logic              CLOCK = 1'b0;
    logic              RESET = 1'b1;
    logic              init_in_h = 1'b0;
    logic [NDEV-1:0]   dev_intreq = '0;
    logic [8*NDEV-1:0] dev_irvec = '0;
    logic              intgnt;
    logic [7:0]        igvec;
    logic              bg_in_h = 1'b0;
    logic              bg_out_h;
    logic              br_out_h;
    logic              sack_out_h;
    logic              bbsy_in_h = 1'b0;
    logic              bbsy_out_h;
    logic              intr_out_h;
    logic              ssyn_in_h = 1'b0;
    logic [15:0]       d_out_h;
    logic              tmo_err;

    int          n_vec  = 0;
    int          n_fail = 0;
    logic [7:0]  sb[$];

    unibus_intr_arb #(.NDEV(NDEV), .TMO(TMO)) dut (
        .CLOCK(CLOCK), .RESET(RESET), .init_in_h(init_in_h),
        .dev_intreq(dev_intreq), .dev_irvec(dev_irvec),
        .intgnt(intgnt), .igvec(igvec),
        .bg_in_h(bg_in_h), .bg_out_h(bg_out_h), .br_out_h(br_out_h),
        .sack_out_h(sack_out_h), .bbsy_in_h(bbsy_in_h), .bbsy_out_h(bbsy_out_h),
        .intr_out_h(intr_out_h), .ssyn_in_h(ssyn_in_h), .d_out_h(d_out_h),
        .tmo_err(tmo_err)
    );

    always #5 CLOCK = ~CLOCK;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic sig(input int sel);
        case (sel)
            0: sig = br_out_h;
            1: sig = bbsy_out_h;
            default: sig = sack_out_h;
        endcase
    endfunction

    // Wait (bounded) at negedges until the selected output reaches val.
    task automatic wait_sig(input string tag, input int sel, input logic val, input int maxc);
        int n = 0;
        while (sig(sel) !== val && n < maxc) begin
            @(negedge CLOCK);
            n++;
        end
        if (sig(sel) !== val) check({tag, "_timeout"}, 32'(sig(sel)), 32'(val));
    endtask

    // Acts as CPU/upstream arbiter for one full vector transaction.
    task automatic serve(input logic [NDEV-1:0] clr_mask);
        logic [7:0] exp_vec;
        exp_vec = (sb.size() != 0) ? sb[0] : 8'hxx;
        wait_sig("br_up", 0, 1'b1, 20);
        check("bg_out_in_req", 32'(bg_out_h), 0);
        bg_in_h = 1'b1;
        @(negedge CLOCK);
        check("sack_br_bgout", {29'b0, sack_out_h, br_out_h, bg_out_h}, 32'b100);
        bg_in_h = 1'b0;
        wait_sig("bbsy_up", 1, 1'b1, 20);
        check("d_out_vec", 32'(d_out_h), {24'b0, exp_vec});
        check("intr_deskew", 32'(intr_out_h), 0);
        @(negedge CLOCK);
        check("intr_on", 32'(intr_out_h), 1);
        ssyn_in_h = 1'b1;
        @(negedge CLOCK);
        check("intgnt", 32'(intgnt), 1);
        if (intgnt) begin
            if (sb.size() == 0) check("unexp_gnt", 32'(intgnt), 0);
            else check("igvec", 32'(igvec), 32'(sb.pop_front()));
        end
        check("done_outs", {12'b0, bbsy_out_h, intr_out_h, d_out_h}, 0);
        ssyn_in_h  = 1'b0;
        dev_intreq = dev_intreq & ~clr_mask;
        @(negedge CLOCK);
        check("intgnt_pulse", 32'(intgnt), 0);
    endtask

    initial begin
        int n;
        logic saw_gnt;
        // Reset
        repeat (2) @(negedge CLOCK);
        check("reset_outs", {br_out_h, sack_out_h, bbsy_out_h, intr_out_h, bg_out_h,
                             intgnt, tmo_err, d_out_h, igvec}, 0);
        RESET = 1'b0;
        @(negedge CLOCK);

        // Single request from dev1, vector 0o310
        dev_irvec[15:8] = 8'o310;
        dev_intreq[1]   = 1'b1;
        sb.push_back(8'o310);
        serve(4'b0010);
        repeat (3) @(negedge CLOCK);
        check("idle_after_single", {29'b0, br_out_h, sack_out_h, bbsy_out_h}, 0);

        // Round robin from rr=0 with dev0 and dev2 held
        RESET = 1'b1;
        @(negedge CLOCK);
        RESET = 1'b0;
        dev_irvec[7:0]   = 8'o100;
        dev_irvec[23:16] = 8'o120;
        dev_intreq       = 4'b0101;
        sb.push_back(8'o100);
        sb.push_back(8'o120);
        sb.push_back(8'o100);
        serve('0);
        serve('0);
        serve(4'b0101);
        repeat (3) @(negedge CLOCK);
        check("rr_sb_empty", sb.size(), 0);

        // Passive withdraw then BG pass-through
        dev_irvec[31:24] = 8'o330;
        dev_intreq[3]    = 1'b1;
        wait_sig("br_dev3", 0, 1'b1, 20);
        dev_intreq[3] = 1'b0;
        @(negedge CLOCK);
        check("withdraw_br_sack", {30'b0, br_out_h, sack_out_h}, 0);
        repeat (2) @(negedge CLOCK);
        bg_in_h = 1'b1;
        @(negedge CLOCK);
        check("bg_pass", 32'(bg_out_h), 1);
        bg_in_h = 1'b0;
        @(negedge CLOCK);
        check("bg_pass_off", 32'(bg_out_h), 0);
        // rr still 1 after withdraw -> dev2 wins over dev0
        dev_intreq = 4'b0101;
        sb.push_back(8'o120);
        serve(4'b0101);

        // Bus busy hold, then timeout (rr=3 -> dev1 wins)
        repeat (2) @(negedge CLOCK);
        dev_intreq[1] = 1'b1;
        bbsy_in_h     = 1'b1;
        wait_sig("br_tmo", 0, 1'b1, 20);
        bg_in_h = 1'b1;
        @(negedge CLOCK);
        bg_in_h = 1'b0;
        repeat (10) @(negedge CLOCK);
        check("waitbus_hold", {30'b0, sack_out_h, bbsy_out_h}, 32'b10);
        bbsy_in_h = 1'b0;
        wait_sig("bbsy_tmo", 1, 1'b1, 20);
        n = 1;
        saw_gnt = 1'b0;
        while (bbsy_out_h && n < int'(TMO) + 20) begin
            @(negedge CLOCK);
            saw_gnt = saw_gnt | intgnt;
            if (bbsy_out_h) n++;
        end
        dev_intreq[1] = 1'b0;
        check("xfer_len", n, TMO);
        check("tmo_err", 32'(tmo_err), 1);
        check("tmo_no_gnt", 32'(saw_gnt), 0);
        repeat (3) @(negedge CLOCK);
        check("tmo_sticky", 32'(tmo_err), 1);

        // INIT during XFER (rr unchanged by timeout -> dev1 again)
        dev_intreq[1] = 1'b1;
        wait_sig("br_init", 0, 1'b1, 20);
        bg_in_h = 1'b1;
        @(negedge CLOCK);
        bg_in_h = 1'b0;
        wait_sig("bbsy_init", 1, 1'b1, 20);
        check("init_pre_d", 32'(d_out_h), 32'o310);
        @(negedge CLOCK);
        init_in_h  = 1'b1;
        dev_intreq = '0;
        bg_in_h    = 1'b1;
        @(negedge CLOCK);
        check("init_outs", {br_out_h, sack_out_h, bbsy_out_h, intr_out_h, bg_out_h,
                            intgnt, tmo_err, d_out_h}, 0);
        init_in_h = 1'b0;
        @(negedge CLOCK);
        check("init_bg_pass", 32'(bg_out_h), 1);
        bg_in_h = 1'b0;
        @(negedge CLOCK);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "bench timeout");
    end

endmodule
